// File: rtl/seq_alu_if.sv
// Request/result bundle between the register-file read side and the sequential ALU.
// The master drives the request; the slave returns registered results and status.
interface seq_alu_if #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
);
  logic         Start;
  logic [3:0]   OP;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic         SC_in;
  logic [W-1:0] Out;
  logic [W-1:0] OutHi;
  logic         SC_out;
  logic         Zero;
  logic         Parity;
  logic         Odd;
  logic         Err;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, OP, InputA, InputB, SC_in,
    input  Out, OutHi, SC_out, Zero, Parity, Odd, Err, Busy, Done
  );

  modport slave (
    input  Start, OP, InputA, InputB, SC_in,
    output Out, OutHi, SC_out, Zero, Parity, Odd, Err, Busy, Done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-step logic/arithmetic, bit-serial shifts and a shift-add
// multiplier, with a start/busy/done handshake and results held between commits.
module seq_alu #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic     Clk,
  input  logic     Reset,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSH = 4'd5;
  localparam logic [3:0] OP_RSH = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_CLR = 4'd8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    op_reg;
  logic [W-1:0]  a_reg, b_reg, hi_reg;
  logic          fill_reg, shout_reg, noshift_reg;
  logic [W-1:0]  out_reg, outhi_reg;
  logic          sc_out_reg, err_reg, busy_reg, done_reg;

  logic [W-1:0]  a_step, b_step, hi_step;
  logic          shout_step;
  logic [W:0]    add_sum, sub_sum, mul_sum;
  logic [W-1:0]  res_lo, res_hi;
  logic          res_sc, res_err;
  logic [SHW-1:0] shamt;
  logic [CW-1:0] load_cnt;

  // Count loaded on accept: shifts take one cycle per bit, MUL one per multiplier bit.
  always_comb begin
    shamt = bus.InputB[SHW-1:0];
    case (bus.OP)
      OP_LSH, OP_RSH: load_cnt = (shamt == '0) ? CW'(1) : CW'(shamt);
      OP_MUL:         load_cnt = CW'(W);
      default:        load_cnt = CW'(1);
    endcase
  end

  // One RUN step, plus the result that would be committed if this is the last step.
  always_comb begin
    a_step     = a_reg;
    b_step     = b_reg;
    hi_step    = hi_reg;
    shout_step = shout_reg;
    add_sum    = {1'b0, a_reg} + {1'b0, b_reg} + {{W{1'b0}}, fill_reg};
    sub_sum    = {1'b0, a_reg} + {1'b0, ~b_reg} + {{W{1'b0}}, 1'b1};
    mul_sum    = {1'b0, hi_reg} + (b_reg[0] ? {1'b0, a_reg} : {(W+1){1'b0}});
    res_lo     = '0;
    res_hi     = '0;
    res_sc     = 1'b0;
    res_err    = 1'b0;
    case (op_reg)
      OP_ADD: {res_sc, res_lo} = add_sum;
      OP_SUB: {res_sc, res_lo} = sub_sum;
      OP_AND: res_lo = a_reg & b_reg;
      OP_OR:  res_lo = a_reg | b_reg;
      OP_XOR: res_lo = a_reg ^ b_reg;
      OP_LSH: begin
        if (!noshift_reg) begin
          shout_step = a_reg[W-1];
          a_step     = {a_reg[W-2:0], fill_reg};
        end
        res_lo = a_step;
        res_sc = shout_step;
      end
      OP_RSH: begin
        if (!noshift_reg) begin
          shout_step = a_reg[0];
          a_step     = {fill_reg, a_reg[W-1:1]};
        end
        res_lo = a_step;
        res_sc = shout_step;
      end
      // Product accumulates in {hi, b}; multiplier bits retire out of b's LSB.
      OP_MUL: begin
        hi_step = mul_sum[W:1];
        b_step  = {mul_sum[0], b_reg[W-1:1]};
        res_lo  = b_step;
        res_hi  = hi_step;
      end
      OP_CLR:  ;
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      hi_reg      <= '0;
      fill_reg    <= 1'b0;
      shout_reg   <= 1'b0;
      noshift_reg <= 1'b0;
      out_reg     <= '0;
      outhi_reg   <= '0;
      sc_out_reg  <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          a_reg     <= a_step;
          b_reg     <= b_step;
          hi_reg    <= hi_step;
          shout_reg <= shout_step;
          cnt_reg   <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            out_reg    <= res_lo;
            outhi_reg  <= res_hi;
            sc_out_reg <= res_sc;
            err_reg    <= res_err;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        default: begin
          if (bus.Start) begin
            op_reg      <= bus.OP;
            a_reg       <= bus.InputA;
            b_reg       <= bus.InputB;
            hi_reg      <= '0;
            fill_reg    <= bus.SC_in;
            shout_reg   <= 1'b0;
            noshift_reg <= (shamt == '0);
            cnt_reg     <= load_cnt;
            busy_reg    <= 1'b1;
            state_reg   <= RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.Out    = out_reg;
  assign bus.OutHi  = outhi_reg;
  assign bus.SC_out = sc_out_reg;
  assign bus.Err    = err_reg;
  assign bus.Busy   = busy_reg;
  assign bus.Done   = done_reg;
  assign bus.Zero   = ~|out_reg;
  assign bus.Parity = ^out_reg;
  assign bus.Odd    = out_reg[0];
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (W=8): directed vector table, back-to-back/illegal and reset
// sequences, then random ops checked against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  seq_alu_if #(.W(W)) bus ();
  seq_alu #(.W(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       sc;
    logic [7:0] e_out;
    logic [7:0] e_hi;
    logic       e_sc;
    logic       e_err;
    int         e_lat;
    int         poke;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic over whole operands.
  function automatic vec_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic sc);
    vec_t v;
    int ai, bi, n, r;
    ai = int'(a);
    bi = int'(b);
    n  = int'(b[2:0]);
    v = '{op, a, b, sc, 8'h00, 8'h00, 1'b0, 1'b0, 1, -1};
    case (op)
      4'd0: begin r = ai + bi + int'(sc); v.e_out = r[7:0]; v.e_sc = r[8]; end
      4'd1: begin r = ai - bi; v.e_out = r[7:0]; v.e_sc = (ai >= bi); end
      4'd2: v.e_out = a & b;
      4'd3: v.e_out = a | b;
      4'd4: v.e_out = a ^ b;
      4'd5: begin
        if (n == 0) v.e_out = a;
        else begin
          r = (ai << n) | (sc ? ((1 << n) - 1) : 0);
          v.e_out = r[7:0];
          v.e_sc  = a[8-n];
          v.e_lat = n;
        end
      end
      4'd6: begin
        if (n == 0) v.e_out = a;
        else begin
          r = (ai >> n) | (sc ? ((255 << (8 - n)) & 255) : 0);
          v.e_out = r[7:0];
          v.e_sc  = a[n-1];
          v.e_lat = n;
        end
      end
      4'd7: begin r = ai * bi; v.e_out = r[7:0]; v.e_hi = r[15:8]; v.e_lat = 8; end
      4'd8: ;
      default: v.e_err = 1'b1;
    endcase
    return v;
  endfunction

  task automatic start_op(input vec_t v);
    bus.Start  = 1'b1;
    bus.OP     = v.op;
    bus.InputA = v.a;
    bus.InputB = v.b;
    bus.SC_in  = v.sc;
  endtask

  // Called with Start already driven; counts edges from accept until Done.
  task automatic wait_done(input int poke, output int lat);
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    bus.OP = 4'hA; bus.InputA = 8'h5A; bus.InputB = 8'hA5; bus.SC_in = 1'b1;
    check("busy_after_accept", bus.Busy, 1);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      lat++;
      if (bus.Done) begin
        bus.Start = 1'b0;
        break;
      end
      if (lat == poke) begin
        bus.Start = 1'b1; bus.OP = 4'd0; bus.InputA = 8'h11; bus.InputB = 8'h22;
      end else begin
        bus.Start = 1'b0;
      end
      check("busy_while_running", bus.Busy, 1);
    end
    check("done_pulse", bus.Done, 1);
    check("busy_low_in_done", bus.Busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input bit b2b, input string tag);
    int lat;
    if (!b2b) @(negedge Clk);
    start_op(v);
    wait_done(v.poke, lat);
    $display("%s op=%0d a=%02h b=%02h sc=%b -> out=%02h hi=%02h sc=%b err=%b lat=%0d",
             tag, v.op, v.a, v.b, v.sc, bus.Out, bus.OutHi, bus.SC_out, bus.Err, lat);
    check({tag, "_out"}, bus.Out, v.e_out);
    check({tag, "_hi"}, bus.OutHi, v.e_hi);
    check({tag, "_sc"}, bus.SC_out, v.e_sc);
    check({tag, "_err"}, bus.Err, v.e_err);
    check({tag, "_lat"}, lat, v.e_lat);
    check({tag, "_zero"}, bus.Zero, (v.e_out == 8'h00));
    check({tag, "_parity"}, bus.Parity, ^v.e_out);
    check({tag, "_odd"}, bus.Odd, v.e_out[0]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out"}, bus.Out, 0);
    check({tag, "_hi"}, bus.OutHi, 0);
    check({tag, "_sc"}, bus.SC_out, 0);
    check({tag, "_err"}, bus.Err, 0);
    check({tag, "_busy"}, bus.Busy, 0);
    check({tag, "_done"}, bus.Done, 0);
    check({tag, "_zero"}, bus.Zero, 1);
    check({tag, "_parity"}, bus.Parity, 0);
    check({tag, "_odd"}, bus.Odd, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   done_seen;

    //           op     a      b      sc    out    hi     sc    err  lat poke
    tbl[0]  = '{4'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1, -1};
    tbl[1]  = '{4'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, 1, -1};
    tbl[2]  = '{4'd1, 8'h07, 8'h05, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1, -1};
    tbl[3]  = '{4'd5, 8'h81, 8'h03, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 3, -1};
    tbl[4]  = '{4'd6, 8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1, -1};
    tbl[5]  = '{4'd5, 8'h5A, 8'h10, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 1, -1};
    tbl[6]  = '{4'd7, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b0, 8, 3};
    tbl[7]  = '{4'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1, -1};
    tbl[8]  = '{4'd8, 8'hAB, 8'hCD, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1, -1};
    tbl[9]  = '{4'd4, 8'hA5, 8'h0F, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, 1, -1};
    tbl[10] = '{4'd0, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 1, -1};
    tbl[11] = '{4'd6, 8'h81, 8'h07, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 7, -1};

    // Reset held 3 edges with a request pending: nothing may start.
    bus.Start = 1'b1; bus.OP = 4'd0; bus.InputA = 8'h01; bus.InputB = 8'h01; bus.SC_in = 1'b0;
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_values("reset");
    @(negedge Clk);
    bus.Start = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("reset_no_start_busy", bus.Busy, 0);
    check("reset_no_start_done", bus.Done, 0);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Back-to-back: illegal op accepted in the DONE cycle, then a legal AND.
    run_vec(model(4'd0, 8'h01, 8'h01, 1'b0), 1'b0, "b2b_add");
    run_vec(model(4'hF, 8'h33, 8'h44, 1'b1), 1'b1, "b2b_illegal");
    run_vec(model(4'd2, 8'hF0, 8'h3C, 1'b0), 1'b1, "b2b_and");

    for (int i = 0; i < 40; i++) begin
      v = model(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
      run_vec(v, 1'($urandom), $sformatf("rnd%0d", i));
    end

    // Make the held result nonzero, then abort a MUL four cycles in.
    run_vec(model(4'd3, 8'h81, 8'h02, 1'b0), 1'b0, "pre_abort");
    @(negedge Clk);
    start_op(model(4'd7, 8'hFF, 8'hFF, 1'b0));
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge Clk);
    Reset = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge Clk); #1;
      if (bus.Done || bus.Busy) done_seen++;
    end
    $display("abort: done/busy cycles after release = %0d", done_seen);
    check("abort_no_done", done_seen, 0);
    run_vec(model(4'd0, 8'h02, 8'h03, 1'b0), 1'b0, "post_abort");
    check("post_abort_value", bus.Out, 8'h05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the combinational datapath ALU. It adds registered results, a start/busy/done handshake, multi-bit shifts executed one bit per cycle, and an unsigned shift-add multiplier with a double-width product. It sits between the register file read ports and the writeback mux. The controller stalls while `Busy` is high and writes back on `Done`.

## Interface
- `W`, default 8: datapath width in bits (W ≥ 4).
- `SHW`, default `$clog2(W)`: width of the shift-amount field taken from `InputB`.
- `Clk`  in  1: the only clock; all state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-low reset (0 = reset).
- `Start`  in  1: request; accepted only when `Busy`=0.
- `OP`  in  4: operation code. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSH, 6 RSH, 7 MUL, 8 CLR; 9–15 are illegal.
- `InputA`, `InputB`  in  W: operands, sampled at accept.
- `SC_in`  in  1: carry-in for ADD, fill bit for LSH/RSH; sampled at accept.
- `Out`  out  W: result, or low half of the MUL product. Registered.
- `OutHi`  out  W: high half of the MUL product, 0 for all other ops. Registered.
- `SC_out`  out  1: carry, borrow-complement or last bit shifted out. Registered.
- `Zero`, `Parity`, `Odd`  out  1 each: `~|Out`, `^Out` and `Out[0]`. Combinational from the `Out` register.
- `Err`  out  1: the last accepted op was illegal. Registered.
- `Busy`  out  1: an operation is in progress.
- `Done`  out  1: one-cycle pulse on completion.

## Operation
- FSM states:
  - IDLE.
  - RUN: internal down-counter `cnt`, width `$clog2(W+1)`.
  - DONE: lasts exactly one cycle.
- Accept: `Start`=1 on an edge in IDLE or DONE. On accept:
  - latch `OP`, `InputA`, `InputB` and `SC_in`;
  - load `cnt`;
  - go to RUN.
  - Back-to-back accept from DONE is legal.
- `cnt` load values:
  - ADD, SUB, AND, OR, XOR, CLR and illegal ops: 1.
  - LSH/RSH: n = `InputB[SHW-1:0]`, or 1 if n = 0.
  - MUL: W.
- Each RUN edge performs one step and decrements `cnt`. The edge where `cnt` goes 1→0 commits the results to `Out`, `OutHi`, `SC_out` and `Err`, and moves to DONE.
- Op definitions, all arithmetic unsigned:
  - ADD: `{SC_out,Out}` = A + B + SC_in, W+1 bits.
  - SUB: `{SC_out,Out}` = A + ~B + 1, W+1 bits. SC_out=1 means no borrow.
  - AND, OR, XOR: bitwise; SC_out = 0.
  - LSH: one step = shift left by 1, fill bit at LSB = SC_in, shifted-out MSB goes to SC_out. After n steps SC_out holds the last bit shifted out.
  - RSH: mirror of LSH (fill at MSB, LSB shifted out).
  - Shift with n = 0: Out = A, SC_out = 0.
  - MUL: shift-add, one multiplier bit per cycle. `{OutHi,Out}` = A × B, 2W bits. SC_out = 0.
  - CLR: all results 0.
  - Illegal op: Out = 0, OutHi = 0, SC_out = 0, Err = 1.
  - `Err` = 0 for every legal op.
- `Out`, `OutHi`, `SC_out` and `Err` hold their values from commit until the next commit. Intermediate step values stay internal and never appear on `Out`.
- `Start` while `Busy`=1 is ignored: no effect on operands, count or outputs.
- `OP` and operand changes after accept have no effect.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0.
  - `Out` = 0, `OutHi` = 0, `SC_out` = 0, `Err` = 0.
  - `Busy` = 0, `Done` = 0.
  - Hence `Zero` = 1, `Parity` = 0, `Odd` = 0.
- Reset mid-operation aborts immediately and asynchronously to the values above. The partial result is discarded and no `Done` is issued.
- Accept at edge E0; `Busy` = 1 from after E0 until commit.
- Commit at edge E0 + `cnt`. `Done` = 1 and `Busy` = 0 for the following cycle.
- Latency from accept to `Done` high:
  - 1 cycle for single-step ops;
  - n cycles for shifts (1 if n = 0);
  - W cycles for MUL.
- Throughput: one op per latency + 1 cycles if `Start` is issued in the DONE cycle.
- `Busy` is low in IDLE and DONE. `Done` is never high together with `Busy`.

## Test plan
- Reset: hold `Reset`=0 for 3 cycles, including one edge with `Start`=1 -> `Out`=0, `OutHi`=0, `Zero`=1, `Busy`=0, `Done`=0, `Err`=0; no operation starts.
- Add and subtract, W=8:
  - ADD A=8'hFF, B=8'h01, SC_in=0 -> `Done` 1 cycle after accept; `Out`=8'h00, `SC_out`=1, `Zero`=1.
  - SUB 8'h05 − 8'h07 -> `Out`=8'hFE, `SC_out`=0.
  - SUB 8'h07 − 8'h05 -> `Out`=8'h02, `SC_out`=1.
- Shifts:
  - LSH A=8'h81, B=3, SC_in=1 -> `Busy` for 3 cycles; `Out`=8'h0F, `SC_out`=0.
  - RSH A=8'h81, B=1, SC_in=0 -> `Out`=8'h40, `SC_out`=1.
  - LSH with B=0 -> `Out`=A, latency 1.
- Multiply: MUL 8'hFF × 8'hFF -> `Done` exactly 8 cycles after accept; `OutHi`=8'hFE, `Out`=8'h01, `Odd`=1. A `Start` pulse with ADD during `Busy` changes nothing.
- Back-to-back and illegal: accept OP=4'hF in the DONE cycle of the previous op -> `Done` 1 cycle later; `Err`=1, `Out`=0. The following legal AND 8'hF0 & 8'h3C -> `Out`=8'h30, `Err`=0.
- Reset mid-op: assert `Reset` 4 cycles into a MUL -> outputs return to reset values immediately and no `Done` is issued. After release, ADD 8'h02 + 8'h03 -> `Out`=8'h05.
